// File: rtl/snake_pkg.sv
// Shared heading definitions for the snake game: direction encoding and the
// 180-degree reversal test. Also used by the head-position logic.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } pend_state_t;

  localparam int NUM_BTNS  = 4;
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  // Same axis (bit 1) but a different heading means a U-turn.
  function automatic logic is_reverse(input dir_t cur, input dir_t cand);
    return (cand[1] == cur[1]) && (cand != cur);
  endfunction

endpackage

// File: rtl/snake_dir_input_btn_debounce.sv
// One button: synchronizer chain, counter-based debouncer and a registered
// one-cycle press pulse on the debounced 0->1 edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   stable_dly_q, stable_dly_d;
  logic                   pulse_q, pulse_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Next-state: shift the sync chain, count consecutive mismatches, and
  // flag the cycle after the debounced level rises.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], raw};
    cnt_d        = '0;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    pulse_d      = stable_q & ~stable_dly_q;
    if (synced != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = synced;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      pulse_q      <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/snake_dir_input.sv
// Direction input front-end: debounces four buttons, picks a candidate
// heading by priority, holds at most one pending change (no U-turns) and
// commits it on the game-step tick.
module snake_dir_input
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_raw,
  input  logic                tick,
  output logic [1:0]          dir,
  output logic                dir_changed,
  output logic [NUM_BTNS-1:0] btn_pulse
);

  pend_state_t state_q, state_d;
  dir_t        dir_q, dir_d;
  dir_t        pending_q, pending_d;
  logic        dir_changed_q, dir_changed_d;

  dir_t        cand;
  logic        cand_vld;
  dir_t        next_dir;
  logic        cand_ok;

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_btn (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[gi]),
      .pulse (btn_pulse[gi])
    );
  end

  // Priority encode the press pulses (up > down > left > right) and judge
  // the candidate against the heading that will be current after this edge.
  always_comb begin
    cand     = DIR_RIGHT;
    cand_vld = |btn_pulse;
    if (btn_pulse[BTN_UP])        cand = DIR_UP;
    else if (btn_pulse[BTN_DOWN]) cand = DIR_DOWN;
    else if (btn_pulse[BTN_LEFT]) cand = DIR_LEFT;
    else                          cand = DIR_RIGHT;
    next_dir = (tick && state_q == ST_PENDING) ? pending_q : dir_q;
    cand_ok  = cand_vld && (cand != next_dir) && !is_reverse(next_dir, cand);
  end

  // Pending FSM: load/overwrite on a valid candidate, commit on tick.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    dir_d         = dir_q;
    dir_changed_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cand_ok) begin
          pending_d = cand;
          state_d   = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (tick) begin
          dir_d         = pending_q;
          dir_changed_d = 1'b1;
          state_d       = ST_IDLE;
        end
        if (cand_ok) begin
          pending_d = cand;
          state_d   = ST_PENDING;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Heading and FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pending_q     <= DIR_RIGHT;
      dir_q         <= DIR_RIGHT;
      dir_changed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      dir_q         <= dir_d;
      dir_changed_q <= dir_changed_d;
    end
  end

  assign dir         = dir_q;
  assign dir_changed = dir_changed_q;

endmodule

// File: tb/tb_snake_dir_input.sv
// Randomized bench for snake_dir_input against a behavioural heading model.
module tb_snake_dir_input;

  localparam int DEB = 4;
  localparam int SS  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] btn_raw;
  logic [1:0] dir;
  logic       dir_changed;
  logic [3:0] btn_pulse;

  always #5 clk = ~clk;

  snake_dir_input #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .tick        (tick),
    .dir         (dir),
    .dir_changed (dir_changed),
    .btn_pulse   (btn_pulse)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit       m_sync   [4][SS];
  int       m_run    [4];
  bit       m_stable [4];
  bit       m_rose   [4];
  bit [3:0] m_pulse;
  bit [1:0] m_dir, m_pend;
  bit       m_pv, m_chg;
  // button index -> heading: right, left, down, up
  bit [1:0] head_of [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < SS; k++) m_sync[i][k] = 1'b0;
      m_run[i]    = 0;
      m_stable[i] = 1'b0;
      m_rose[i]   = 1'b0;
    end
    m_pulse = '0;
    m_dir   = 2'b00;
    m_pend  = 2'b00;
    m_pv    = 1'b0;
    m_chg   = 1'b0;
  endtask

  task automatic m_step(input bit r, input bit t, input bit [3:0] raw);
    bit [1:0] nd, cand;
    bit       synced, rose_now;
    if (r) begin
      m_reset();
      return;
    end
    // heading: uses the pulses visible before this edge
    nd    = (t && m_pv) ? m_pend : m_dir;
    m_chg = 1'b0;
    if (t && m_pv) begin
      m_dir = m_pend;
      m_chg = 1'b1;
      m_pv  = 1'b0;
    end
    if (m_pulse != 0) begin
      cand = 2'b00;
      for (int i = 0; i < 4; i++) if (m_pulse[i]) cand = head_of[i];
      // a legal turn is one onto the perpendicular axis
      if (cand[1] != nd[1]) begin
        m_pend = cand;
        m_pv   = 1'b1;
      end
    end
    // buttons: stable flips after DEB consecutive mismatching edges
    for (int i = 0; i < 4; i++) begin
      synced   = m_sync[i][SS-1];
      for (int k = SS-1; k > 0; k--) m_sync[i][k] = m_sync[i][k-1];
      m_sync[i][0] = raw[i];
      rose_now = 1'b0;
      if (synced != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_stable[i] = synced;
          m_run[i]    = 0;
          rose_now    = synced;
        end
      end else begin
        m_run[i] = 0;
      end
      m_pulse[i] = m_rose[i];
      m_rose[i]  = rose_now;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step(rst, tick, btn_raw);
    #1;
    chk("dir", dir, m_dir);
    chk("dir_changed", dir_changed, m_chg);
    chk("btn_pulse", btn_pulse, m_pulse);
  endtask

  int hold [4];
  int rst_left;
  int lat;

  initial begin
    rst = 1'b1;
    tick = 1'b0;
    btn_raw = '0;
    m_reset();
    repeat (3) cycle();
    chk("reset_dir", dir, 2'b00);
    chk("reset_pulse", btn_pulse, 4'b0000);

    // directed clean press of up: pulse latency, then commit on tick
    rst = 1'b0;
    btn_raw = 4'b1000;
    lat = 0;
    while (lat < 40) begin
      cycle();
      lat++;
      if (btn_pulse[3]) break;
    end
    chk("press_latency", lat, 7);
    repeat (12) cycle();
    btn_raw = '0;
    repeat (10) cycle();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    chk("commit_up", dir, 2'b10);
    chk("commit_pulse", dir_changed, 1'b1);
    cycle();
    chk("changed_one_cycle", dir_changed, 1'b0);

    // randomized phase: bouncy buttons, random ticks, occasional reset
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 12);
    rst_left = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          btn_raw[i] = ~btn_raw[i];
          hold[i]    = $urandom_range(1, 12);
        end
      end
      tick = ($urandom_range(0, 3) == 0);
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
      rst = (rst_left > 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
